// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-controller types: FSM state encoding and the wrapping PC increment.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_REQ  = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_ctrl_hold_buf.sv
// Single-entry parking slot for a fetched word that completed while decode was stalled.
// Load captures in one edge, unload empties it; contents survive until overwritten.
module fetch_ctrl_hold_buf (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_vld
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_vld;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_instr <= 32'd0;
      r_pc    <= 32'd0;
      r_vld   <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_vld   <= 1'b1;
    end else if (i_unload) begin
      r_vld   <= 1'b0;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_vld   = r_vld;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one outstanding imem request, delay-slot redirects, registered IF/ID output.
// Output updates on the edge after mem_ready; stall_d freezes the output and parks one word in HOLD.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter bit          USE_START_ADDR = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] start_addr,
  input  logic        pc_src_d,
  input  logic [31:0] pc_branch_d,
  input  logic        stall_d,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        valid_f,
  output logic [31:0] instruction_f,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus_4_f
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_armed;
  logic [31:0] r_pc;
  logic        r_pending;
  logic [31:0] r_pend_tgt;
  logic        r_valid_f;
  logic [31:0] r_instr_f;
  logic [31:0] r_pc_f;

  logic        w_slot_free;
  logic        w_redir;
  logic [31:0] w_next_pc;
  logic [31:0] w_boot_pc;
  logic        w_fetch_done;
  logic        w_hold_load;
  logic        w_hold_unload;
  logic        w_consume;
  logic [31:0] w_hold_instr;
  logic [31:0] w_hold_pc;
  logic        w_hold_vld;

  assign w_slot_free = ~r_valid_f | ~stall_d;
  assign w_redir     = pc_src_d & ~stall_d;
  assign w_boot_pc   = USE_START_ADDR ? start_addr : RESET_PC;
  assign w_next_pc   = w_redir   ? pc_branch_d :
                       r_pending ? r_pend_tgt  : pc_inc(r_pc);
  assign w_consume   = w_fetch_done | w_hold_unload;

  always_comb begin
    w_state_nxt   = r_state;
    w_fetch_done  = 1'b0;
    w_hold_load   = 1'b0;
    w_hold_unload = 1'b0;
    case (r_state)
      ST_BOOT: begin
        if (r_armed) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (mem_ready) begin
          if (w_slot_free) begin
            w_fetch_done = 1'b1;
          end else begin
            w_hold_load = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!stall_d && w_hold_vld) begin
          w_hold_unload = 1'b1;
          w_state_nxt   = ST_REQ;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // The first edge after reset release only arms the FSM, so BOOT samples start_addr a full cycle later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_BOOT;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc       <= 32'd0;
      r_pending  <= 1'b0;
      r_pend_tgt <= 32'd0;
    end else begin
      if (r_state == ST_BOOT && r_armed) begin
        r_pc <= w_boot_pc;
      end else if (w_consume) begin
        r_pc <= w_next_pc;
      end
      if (w_consume) begin
        r_pending <= 1'b0;
      end else if (w_redir) begin
        r_pending  <= 1'b1;
        r_pend_tgt <= pc_branch_d;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid_f <= 1'b0;
      r_instr_f <= 32'd0;
      r_pc_f    <= 32'd0;
    end else if (w_fetch_done) begin
      r_valid_f <= 1'b1;
      r_instr_f <= mem_rdata;
      r_pc_f    <= r_pc;
    end else if (w_hold_unload) begin
      r_valid_f <= 1'b1;
      r_instr_f <= w_hold_instr;
      r_pc_f    <= w_hold_pc;
    end else if (!stall_d) begin
      r_valid_f <= 1'b0;
    end
  end

  fetch_ctrl_hold_buf u_hold_buf (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_load   (w_hold_load),
    .i_unload (w_hold_unload),
    .i_instr  (mem_rdata),
    .i_pc     (r_pc),
    .o_instr  (w_hold_instr),
    .o_pc     (w_hold_pc),
    .o_vld    (w_hold_vld)
  );

  assign mem_req       = (r_state == ST_REQ);
  assign mem_addr      = r_pc;
  assign valid_f       = r_valid_f;
  assign instruction_f = r_instr_f;
  assign pc_f          = r_pc_f;
  assign pc_plus_4_f   = pc_inc(r_pc_f);

endmodule
